// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared opcode/width defines plus the arbiter state encoding
// and requester-id constants.
//
// The guarded define block is the codebase-wide opcode set (`ADD..`BEQ) and
// default datapath width (`DSIZE). Any file may repeat it verbatim; the
// guard keeps the definitions single.
//
// Optional feature macro: ALU_ARB_MUL_MULTICYCLE_EN (adds the MULW state).
`ifndef ALU_DEFINES_VH
`define ALU_DEFINES_VH
`define DSIZE 32
`define ADD   4'h0
`define SUB   4'h1
`define AND   4'h2
`define OR    4'h3
`define XOR   4'h4
`define SLL   4'h5
`define SRL   4'h6
`define MUL   4'h7
`define BEQ   4'h8
`endif

package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
      MULW = 2'd2,
`endif
      RESP = 2'd3
   } arb_state_t;

   localparam logic ID_REQ0 = 1'b0;
   localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/alu_arbiter_rr.sv
// rr_arbiter2: two-way round-robin grant.
//
// Ports:
//   req[1:0]   - request vector (bit n = requester n valid)
//   last       - index of the requester granted most recently
//   grant[1:0] - one-hot grant; all zero when nothing is requested
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] grant
);

   always_comb begin
      grant = '0;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         // On a tie, favour whoever was not served last.
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external ALU between two requesters
// (0 = pipeline EX, 1 = debug/test port). One operation is in flight at a time.
//
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   reqN_valid/ready          - request handshake, N = 0,1
//   reqN_op/a/b/imm           - request operands
//   alu_op/a/b/imm            - registered operands driven to the shared ALU
//   alu_out, alu_zero         - ALU result inputs
//   rsp_valid/ready           - response handshake
//   rsp_id, rsp_data, rsp_zero - response payload (requester index, result)
//
// Optional feature macro ALU_ARB_MUL_MULTICYCLE_EN: `MUL is held in MULW so the
// ALU gets MUL_CYCLES cycles to settle. Without it, MUL_CYCLES is only
// range-checked.
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DSIZE      = `DSIZE,
   parameter int MUL_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_op,
   input  logic [DSIZE-1:0] req0_a,
   input  logic [DSIZE-1:0] req0_b,
   input  logic [DSIZE-1:0] req0_imm,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_op,
   input  logic [DSIZE-1:0] req1_a,
   input  logic [DSIZE-1:0] req1_b,
   input  logic [DSIZE-1:0] req1_imm,
   output logic [3:0]       alu_op,
   output logic [DSIZE-1:0] alu_a,
   output logic [DSIZE-1:0] alu_b,
   output logic [DSIZE-1:0] alu_imm,
   input  logic [DSIZE-1:0] alu_out,
   input  logic             alu_zero,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [DSIZE-1:0] rsp_data,
   output logic             rsp_zero
);

   if (MUL_CYCLES < 2 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
      $error("alu_arbiter: MUL_CYCLES must be in 2..15");
   end

   arb_state_t       state;
   logic             last_grant;
   logic [1:0]       grant;
   logic [3:0]       op_r;
   logic [DSIZE-1:0] a_r;
   logic [DSIZE-1:0] b_r;
   logic [DSIZE-1:0] imm_r;
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
   logic [3:0]       mul_cnt;
`endif

   rr_arbiter2 u_rr (
      .req   ({req1_valid, req0_valid}),
      .last  (last_grant),
      .grant (grant)
   );

   // Ready is the grant itself, qualified by IDLE and reset, so a requester
   // only ever sees ready while it is valid and chosen.
   assign req0_ready = (state == IDLE) && !rst && grant[0];
   assign req1_ready = (state == IDLE) && !rst && grant[1];

   assign alu_op  = op_r;
   assign alu_a   = a_r;
   assign alu_b   = b_r;
   assign alu_imm = imm_r;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         op_r       <= '0;
         a_r        <= '0;
         b_r        <= '0;
         imm_r      <= '0;
         rsp_valid  <= 1'b0;
         rsp_id     <= ID_REQ0;
         rsp_data   <= '0;
         rsp_zero   <= 1'b0;
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
         mul_cnt    <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (grant[1]) begin
                  op_r       <= req1_op;
                  a_r        <= req1_a;
                  b_r        <= req1_b;
                  imm_r      <= req1_imm;
                  rsp_id     <= ID_REQ1;
                  last_grant <= 1'b1;
                  state      <= EXEC;
               end else if (grant[0]) begin
                  op_r       <= req0_op;
                  a_r        <= req0_a;
                  b_r        <= req0_b;
                  imm_r      <= req0_imm;
                  rsp_id     <= ID_REQ0;
                  last_grant <= 1'b0;
                  state      <= EXEC;
               end
            end
            EXEC: begin
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
               if (op_r == `MUL) begin
                  // EXEC is the first settle cycle; MULW covers the rest.
                  mul_cnt <= 4'(MUL_CYCLES - 2);
                  state   <= MULW;
               end else
`endif
               begin
                  rsp_data  <= alu_out;
                  rsp_zero  <= alu_zero;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
`ifdef ALU_ARB_MUL_MULTICYCLE_EN
            MULW: begin
               if (mul_cnt == '0) begin
                  rsp_data  <= alu_out;
                  rsp_zero  <= alu_zero;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  mul_cnt <= mul_cnt - 4'd1;
               end
            end
`endif
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
`ifndef ALU_DEFINES_VH
`define ALU_DEFINES_VH
`define DSIZE 32
`define ADD   4'h0
`define SUB   4'h1
`define AND   4'h2
`define OR    4'h3
`define XOR   4'h4
`define SLL   4'h5
`define SRL   4'h6
`define MUL   4'h7
`define BEQ   4'h8
`endif

module tb_alu_arbiter;

   localparam int W = `DSIZE;

`ifdef ALU_ARB_MUL_MULTICYCLE_EN
   localparam int MUL_LAT = 4;
`else
   localparam int MUL_LAT = 2;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req0_ready;
   logic [3:0]   req0_op;
   logic [W-1:0] req0_a, req0_b, req0_imm;
   logic         req1_valid, req1_ready;
   logic [3:0]   req1_op;
   logic [W-1:0] req1_a, req1_b, req1_imm;
   logic [3:0]   alu_op;
   logic [W-1:0] alu_a, alu_b, alu_imm, alu_out;
   logic         alu_zero;
   logic         rsp_valid, rsp_ready, rsp_id, rsp_zero;
   logic [W-1:0] rsp_data;

   int total = 0;
   int bad   = 0;

   alu_arbiter #(.DSIZE(W), .MUL_CYCLES(3)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b), .req0_imm(req0_imm),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b), .req1_imm(req1_imm),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm),
      .alu_out(alu_out), .alu_zero(alu_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero)
   );

   always #5 clk = ~clk;

   // Stand-in for the shared ALU (stimulus only).
   always_comb begin
      case (alu_op)
         `ADD:    alu_out = alu_a + alu_b;
         `SUB:    alu_out = alu_a - alu_b;
         `AND:    alu_out = alu_a & alu_b;
         `OR:     alu_out = alu_a | alu_b;
         `XOR:    alu_out = alu_a ^ alu_b;
         `SLL:    alu_out = alu_a << alu_imm[4:0];
         `SRL:    alu_out = alu_a >> alu_imm[4:0];
         `MUL:    alu_out = alu_a * alu_b;
         `BEQ:    alu_out = alu_a - alu_b;
         default: alu_out = alu_a;
      endcase
      alu_zero = (alu_out == '0);
   end

   // Wait for requester idx to be granted, then drop its valid after the edge.
   task automatic do_accept(input int idx, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if ((idx == 0 && req0_ready) || (idx == 1 && req1_ready)) begin
            @(posedge clk);
            #1;
            if (idx == 0) req0_valid = 1'b0;
            else          req1_valid = 1'b0;
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Called #1 after the accept edge; n = edges from accept (inclusive) until
   // rsp_valid is seen. Returns sampled at the negedge where rsp_valid is high.
   task automatic wait_rsp(output int n);
      n = 1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (rsp_valid) return;
         @(posedge clk);
         n++;
      end
      n = -1;
   endtask

   task automatic test_reset;
      bit ok;
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_op = `ADD; req0_a = 5; req0_b = 3; req0_imm = 0;
      req1_op = `ADD; req1_a = 1; req1_b = 1; req1_imm = 0;
      rsp_ready = 1'b1;
      #12;
      ok = !req0_ready && !req1_ready;
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL reset_ready: r0=%0b r1=%0b want 0 0", req0_ready, req1_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
      total++; if ({alu_op, alu_a, alu_b, alu_imm} !== '0) begin bad++; $display("FAIL reset_alu_regs: op=%0h a=%0h want 0", alu_op, alu_a); end
      total++; if ({rsp_id, rsp_data, rsp_zero} !== '0) begin bad++; $display("FAIL reset_rsp_regs: id=%0b data=%0h zero=%0b want 0", rsp_id, rsp_data, rsp_zero); end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add;
      bit ok; int n;
      req0_op = `ADD; req0_a = 5; req0_b = 3; req0_imm = 0; req0_valid = 1'b1;
      do_accept(0, ok);
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL add_accept: timeout"); end
      wait_rsp(n);
      total++; if (n != 2) begin bad++; $display("FAIL add_latency: got %0d want 2", n); end
      total++; if (rsp_id !== 1'b0 || rsp_data !== 32'd8 || rsp_zero !== 1'b0) begin
         bad++; $display("FAIL add_rsp: id=%0b data=%0d zero=%0b want 0 8 0", rsp_id, rsp_data, rsp_zero); end
      @(posedge clk); #1;
   endtask

   task automatic test_tie;
      bit ok; int n;
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      req0_op = `SUB; req0_a = 7; req0_b = 7; req0_imm = 0;
      req1_op = `XOR; req1_a = 6; req1_b = 3; req1_imm = 0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         bad++; $display("FAIL tie1_grant: r0=%0b r1=%0b want 1 0", req0_ready, req1_ready); end
      do_accept(0, ok);
      wait_rsp(n);
      total++; if (!ok || n != 2 || rsp_id !== 1'b0 || rsp_data !== 32'd0 || rsp_zero !== 1'b1) begin
         bad++; $display("FAIL tie1_rsp: n=%0d id=%0b data=%0d zero=%0b want 2 0 0 1", n, rsp_id, rsp_data, rsp_zero); end
      do_accept(1, ok);
      wait_rsp(n);
      total++; if (!ok || n != 2 || rsp_id !== 1'b1 || rsp_data !== 32'd5 || rsp_zero !== 1'b0) begin
         bad++; $display("FAIL tie2_rsp: n=%0d id=%0b data=%0d zero=%0b want 2 1 5 0", n, rsp_id, rsp_data, rsp_zero); end
      @(posedge clk);
      @(negedge clk);
      req0_op = `ADD; req0_a = 1; req0_b = 1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         bad++; $display("FAIL tie3_grant: r0=%0b r1=%0b want 1 0", req0_ready, req1_ready); end
      do_accept(0, ok);
      req1_valid = 1'b0;
      wait_rsp(n);
      total++; if (rsp_id !== 1'b0 || rsp_data !== 32'd2) begin
         bad++; $display("FAIL tie3_rsp: id=%0b data=%0d want 0 2", rsp_id, rsp_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_stall;
      bit ok; int n; int errs;
      rsp_ready = 1'b0;
      req1_op = `SLL; req1_a = 1; req1_b = 0; req1_imm = 4; req1_valid = 1'b1;
      do_accept(1, ok);
      wait_rsp(n);
      total++; if (!ok || n != 2) begin bad++; $display("FAIL stall_latency: ok=%0b n=%0d want 2", ok, n); end
      req0_op = `ADD; req0_a = 9; req0_b = 9; req0_imm = 0; req0_valid = 1'b1;
      errs = 0;
      for (int i = 0; i < 5; i++) begin
         // Operands of a waiting requester may change freely while not ready.
         req0_a = W'(i);
         #1;
         if (rsp_valid !== 1'b1 || rsp_data !== 32'd16 || rsp_id !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0)
            errs++;
         @(negedge clk);
      end
      total++; if (errs != 0) begin
         bad++; $display("FAIL stall_hold: %0d bad cycles want 0 (v=%0b data=%0d r0=%0b r1=%0b)", errs, rsp_valid, rsp_data, req0_ready, req1_ready); end
      req0_a = 1; req0_b = 1;
      rsp_ready = 1'b1;
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0 || req0_ready !== 1'b1) begin
         bad++; $display("FAIL stall_release: v=%0b r0=%0b want 0 1", rsp_valid, req0_ready); end
      do_accept(0, ok);
      wait_rsp(n);
      total++; if (rsp_id !== 1'b0 || rsp_data !== 32'd2) begin
         bad++; $display("FAIL stall_next: id=%0b data=%0d want 0 2", rsp_id, rsp_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_mul;
      bit ok; int n;
      req0_op = `MUL; req0_a = 6; req0_b = 7; req0_imm = 0; req0_valid = 1'b1;
      do_accept(0, ok);
      wait_rsp(n);
      total++; if (!ok || n != MUL_LAT) begin bad++; $display("FAIL mul_latency: got %0d want %0d", n, MUL_LAT); end
      total++; if (rsp_data !== 32'd42 || rsp_zero !== 1'b0) begin
         bad++; $display("FAIL mul_data: data=%0d zero=%0b want 42 0", rsp_data, rsp_zero); end
      @(posedge clk); #1;
   endtask

   task automatic test_unknown_op;
      bit ok; int n;
      req1_op = 4'hE; req1_a = 32'h55; req1_b = 1; req1_imm = 0; req1_valid = 1'b1;
      do_accept(1, ok);
      total++; if (alu_op !== 4'hE || alu_a !== 32'h55) begin
         bad++; $display("FAIL unk_forward: op=%0h a=%0h want e 55", alu_op, alu_a); end
      wait_rsp(n);
      total++; if (!ok || n != 2 || rsp_data !== 32'h55 || rsp_id !== 1'b1) begin
         bad++; $display("FAIL unk_rsp: n=%0d data=%0h id=%0b want 2 55 1", n, rsp_data, rsp_id); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      bit ok; int n; int errs;
      req0_op = `ADD; req0_a = 9; req0_b = 9; req0_imm = 3; req0_valid = 1'b1;
      do_accept(0, ok);
      req1_op = `ADD; req1_a = 2; req1_b = 2; req1_imm = 0; req1_valid = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      total++; if (!ok || {alu_op, alu_a, alu_b, alu_imm} !== '0) begin
         bad++; $display("FAIL rstmid_alu: ok=%0b op=%0h a=%0d b=%0d want 0", ok, alu_op, alu_a, alu_b); end
      total++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         bad++; $display("FAIL rstmid_out: v=%0b data=%0d id=%0b r0=%0b r1=%0b want 0", rsp_valid, rsp_data, rsp_id, req0_ready, req1_ready); end
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      errs = 0;
      // The dropped request must never produce a response.
      n = 0;
      do_accept(1, ok);
      for (int k = 0; k < 30 && rsp_valid !== 1'b1; k++) begin
         if (rsp_valid === 1'b1 && rsp_id !== 1'b1) errs++;
         @(negedge clk);
         n++;
      end
      total++; if (!ok || rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_data !== 32'd4 || errs != 0) begin
         bad++; $display("FAIL rstmid_next: v=%0b id=%0b data=%0d want 1 1 4", rsp_valid, rsp_id, rsp_data); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      int errs; int rsps;
      req1_valid = 1'b0;
      req0_op = `ADD; req0_a = 1; req0_b = 2; req0_imm = 0; req0_valid = 1'b1;
      errs = 0; rsps = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (req0_ready !== (i % 3 == 0) || req1_ready !== 1'b0 || rsp_valid !== (i % 3 == 2))
            errs++;
         if (rsp_valid === 1'b1) begin
            rsps++;
            if (rsp_id !== 1'b0 || rsp_data !== 32'd3) errs++;
         end
      end
      req0_valid = 1'b0;
      total++; if (errs != 0 || rsps != 3) begin
         bad++; $display("FAIL b2b_pattern: errs=%0d rsps=%0d want 0 3", errs, rsps); end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: sim time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      test_reset;
      test_add;
      test_tie;
      test_stall;
      test_mul;
      test_unknown_op;
      test_reset_mid;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
